// File: rtl/my_uart_rx_pkg.sv
// Shared constants and state encoding for the UART receiver.
package my_uart_rx_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/my_uart_rx.sv
// UART receiver: 8 data bits, LSB first, one parity bit, one stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
import my_uart_rx_pkg::*;

module my_uart_rx #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rx_ok,
    output logic       err_check,
    output logic       err_frame
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 rx_s;
    logic                 rx_d;
    logic                 fall;
    logic                 smp;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_d <= 1'b1;
        else        rx_d <= rx_s;
    end

    assign fall = rx_d & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    // Window is rx_d2/rx_d/rx_s, so decision points stay where they are.
    logic rx_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_d2 <= 1'b1;
        else        rx_d2 <= rx_d;
    end

    assign smp = (rx_d2 & rx_d) | (rx_d2 & rx_s) | (rx_d & rx_s);
`else
    assign smp = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            dataout   <= '0;
            rx_ok     <= 1'b0;
            err_check <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            rx_ok <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (fall) state <= S_START;
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= smp ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= smp;
                        idx        <= idx + 1'b1;
                        if (idx == IDX_LAST) state <= S_PARITY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        perr  <= ((^shreg) ^ smp) != PARITY_ODD;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop lets the next start edge be seen.
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        dataout   <= shreg;
                        err_check <= perr;
                        err_frame <= ~smp;
                        rx_ok     <= ~perr & smp;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_my_uart_rx.sv
// Directed bench for my_uart_rx: 20 MHz clock, 800 ns bit time.
module tb_my_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] dataout;
    logic       rx_ok;
    logic       err_check;
    logic       err_frame;

    int checks;
    int errors;
    int ok_cnt;
    int ok_base;

    my_uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .dataout   (dataout),
        .rx_ok     (rx_ok),
        .err_check (err_check),
        .err_frame (err_frame)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ok) ok_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp);
        rx = 1'b0;
        #800;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #800;
        end
        rx = par;
        #800;
        rx = stp;
        #800;
        rx = 1'b1;
    endtask

    task automatic frame_check(input string tag, input logic [7:0] d,
                               input logic par, input logic stp,
                               input logic [7:0] exp_d, input logic exp_pe,
                               input logic exp_fe, input int exp_ok);
        ok_base = ok_cnt;
        send_frame(d, par, stp);
        #1600;
        chk({tag, "_data"}, 32'(dataout), 32'(exp_d));
        chk({tag, "_errchk"}, 32'(err_check), 32'(exp_pe));
        chk({tag, "_errfrm"}, 32'(err_frame), 32'(exp_fe));
        chk({tag, "_okcnt"}, 32'(ok_cnt - ok_base), 32'(exp_ok));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ok_cnt = 0;
        rst_n  = 1'b0;
        rx     = 1'b1;

        #100;
        chk("rst_data", 32'(dataout), 32'h00);
        chk("rst_ok", 32'(rx_ok), 32'h0);
        #1125;
        rst_n = 1'b1;

        #8000;
        chk("idle_data", 32'(dataout), 32'h00);
        chk("idle_errchk", 32'(err_check), 32'h0);
        chk("idle_errfrm", 32'(err_frame), 32'h0);
        chk("idle_okcnt", 32'(ok_cnt), 32'd0);

        frame_check("f93", 8'h93, 1'b0, 1'b1, 8'h93, 1'b0, 1'b0, 1);

        #2400;
        frame_check("f8e", 8'h8E, 1'b0, 1'b1, 8'h8E, 1'b0, 1'b0, 1);

        frame_check("par", 8'h93, 1'b1, 1'b1, 8'h93, 1'b1, 1'b0, 0);

        frame_check("stop", 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0);

        frame_check("fa5", 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1);

        ok_base = ok_cnt;
        rx = 1'b0;
        #300;
        rx = 1'b1;
        #4000;
        chk("glitch_data", 32'(dataout), 32'hA5);
        chk("glitch_state", 32'(dut.state), 32'd0);
        chk("glitch_okcnt", 32'(ok_cnt - ok_base), 32'd0);

        ok_base = ok_cnt;
        rx = 1'b0;
        #800;
        rx = 1'b1;
        #1600;
        rx = 1'b0;
        #400;
        rst_n = 1'b0;
        #1;
        chk("mrst_data", 32'(dataout), 32'h00);
        chk("mrst_errchk", 32'(err_check), 32'h0);
        chk("mrst_errfrm", 32'(err_frame), 32'h0);
        #200;
        rx = 1'b1;
        #100;
        rst_n = 1'b1;
        #9600;
        chk("mrst_okcnt", 32'(ok_cnt - ok_base), 32'd0);
        chk("mrst_hold", 32'(dataout), 32'h00);

        frame_check("rec", 8'h8E, 1'b0, 1'b1, 8'h8E, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
